// File: rtl/id_ex_stage.sv
// ID/EX boundary of the 5-stage MIPS pipeline: decodes the ID instruction, bypasses
// same-cycle writeback data, detects load-use hazards and registers the EX slot.
module id_ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_id_valid,
   input  logic [31:0] if_id_instr,
   input  logic [31:0] if_id_pc_plus4,
   input  logic [31:0] rf_rs_data,
   input  logic [31:0] rf_rt_data,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_write_register,
   input  logic [31:0] wb_write_data,
   input  logic        wb_jal_write,
   input  logic [31:0] wb_pc_plus4,
   input  logic        flush,
   output logic        stall,
   output logic        id_ex_valid,
   output logic        id_ex_mem_read,
   output logic [31:0] id_ex_pc_plus4,
   output logic [31:0] id_ex_rs_val,
   output logic [31:0] id_ex_rt_val,
   output logic [4:0]  id_ex_rs,
   output logic [4:0]  id_ex_rt,
   output logic [4:0]  id_ex_rd,
   output logic [4:0]  id_ex_shamt,
   output logic [5:0]  id_ex_opcode,
   output logic [5:0]  id_ex_funct,
   output logic [31:0] id_ex_imm
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [15:0] imm16;
   logic        rs_used;
   logic        rt_used;
   logic        is_load;
   logic        zero_ext;
   logic [31:0] imm_ext;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        hazard;

   assign opcode = if_id_instr[31:26];
   assign rs     = if_id_instr[25:21];
   assign rt     = if_id_instr[20:16];
   assign rd     = if_id_instr[15:11];
   assign shamt  = if_id_instr[10:6];
   assign funct  = if_id_instr[5:0];
   assign imm16  = if_id_instr[15:0];

   always_comb begin
      rs_used  = !(opcode inside {6'h02, 6'h03, 6'h0F});
      rt_used  = opcode inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
      is_load  = opcode inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
      zero_ext = opcode inside {6'h0C, 6'h0D, 6'h0E};
      imm_ext  = zero_ext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
   end

   // Same priority order as the register file's write port, so a read in the
   // write cycle sees exactly what the file will hold after the edge.
   function automatic logic [31:0] wb_bypass(
      input logic [4:0]  idx,
      input logic [31:0] rf_data,
      input logic        reg_write,
      input logic [4:0]  wr_reg,
      input logic [31:0] wr_data,
      input logic        jal_write,
      input logic [31:0] link
   );
      if (idx == 5'd0)
         return 32'h0;
      else if (reg_write && wr_reg == idx)
         return wr_data;
      else if (idx == 5'd31 && jal_write && !(reg_write && wr_reg != 5'd0))
         return link;
      else
         return rf_data;
   endfunction

   assign rs_val = wb_bypass(rs, rf_rs_data, wb_reg_write, wb_write_register,
                             wb_write_data, wb_jal_write, wb_pc_plus4);
   assign rt_val = wb_bypass(rt, rf_rt_data, wb_reg_write, wb_write_register,
                             wb_write_data, wb_jal_write, wb_pc_plus4);

   assign hazard = if_id_valid && id_ex_valid && id_ex_mem_read && (id_ex_rt != 5'd0) &&
                   ((rs_used && rs == id_ex_rt) || (rt_used && rt == id_ex_rt));
   assign stall  = hazard && !flush;

   // Flush and stall both insert an all-zero bubble; the bubble clears mem_read,
   // which is what limits a load-use stall to a single cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset || flush || hazard) begin
         id_ex_valid    <= 1'b0;
         id_ex_mem_read <= 1'b0;
         id_ex_pc_plus4 <= 32'h0;
         id_ex_rs_val   <= 32'h0;
         id_ex_rt_val   <= 32'h0;
         id_ex_rs       <= 5'd0;
         id_ex_rt       <= 5'd0;
         id_ex_rd       <= 5'd0;
         id_ex_shamt    <= 5'd0;
         id_ex_opcode   <= 6'd0;
         id_ex_funct    <= 6'd0;
         id_ex_imm      <= 32'h0;
      end else begin
         id_ex_valid    <= if_id_valid;
         id_ex_mem_read <= is_load && if_id_valid;
         id_ex_pc_plus4 <= if_id_pc_plus4;
         id_ex_rs_val   <= rs_val;
         id_ex_rt_val   <= rt_val;
         id_ex_rs       <= rs;
         id_ex_rt       <= rt;
         id_ex_rd       <= rd;
         id_ex_shamt    <= shamt;
         id_ex_opcode   <= opcode;
         id_ex_funct    <= funct;
         id_ex_imm      <= imm_ext;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, field decode, WB/JAL bypass, immediates,
// load-use stalls and flush priority, with hand-computed expectations.
module tb_id_ex_stage;

   localparam logic [31:0] ADD_3_5_6   = 32'h00A61820;
   localparam logic [31:0] ADD_3_0_5   = 32'h00051820;
   localparam logic [31:0] ADD_10_8_11 = 32'h010B5020;
   localparam logic [31:0] LW_8_9      = 32'h8D280000;
   localparam logic [31:0] LW_10_8     = 32'h8D0A0000;
   localparam logic [31:0] SW_8_2      = 32'hAC480004;
   localparam logic [31:0] ADDI_8_8    = 32'h21080001;
   localparam logic [31:0] ADDI_8_9    = 32'h21280001;
   localparam logic [31:0] JR_31       = 32'h03E00008;
   localparam logic [31:0] ORI_8000    = 32'h34018000;
   localparam logic [31:0] ADDI_8000   = 32'h20018000;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] rf_rs_data;
   logic [31:0] rf_rt_data;
   logic        wb_reg_write;
   logic [4:0]  wb_write_register;
   logic [31:0] wb_write_data;
   logic        wb_jal_write;
   logic [31:0] wb_pc_plus4;
   logic        flush;
   logic        stall;
   logic        id_ex_valid;
   logic        id_ex_mem_read;
   logic [31:0] id_ex_pc_plus4;
   logic [31:0] id_ex_rs_val;
   logic [31:0] id_ex_rt_val;
   logic [4:0]  id_ex_rs;
   logic [4:0]  id_ex_rt;
   logic [4:0]  id_ex_rd;
   logic [4:0]  id_ex_shamt;
   logic [5:0]  id_ex_opcode;
   logic [5:0]  id_ex_funct;
   logic [31:0] id_ex_imm;

   int checks   = 0;
   int failures = 0;

   id_ex_stage dut (
      .clk              (clk),
      .reset            (reset),
      .if_id_valid      (if_id_valid),
      .if_id_instr      (if_id_instr),
      .if_id_pc_plus4   (if_id_pc_plus4),
      .rf_rs_data       (rf_rs_data),
      .rf_rt_data       (rf_rt_data),
      .wb_reg_write     (wb_reg_write),
      .wb_write_register(wb_write_register),
      .wb_write_data    (wb_write_data),
      .wb_jal_write     (wb_jal_write),
      .wb_pc_plus4      (wb_pc_plus4),
      .flush            (flush),
      .stall            (stall),
      .id_ex_valid      (id_ex_valid),
      .id_ex_mem_read   (id_ex_mem_read),
      .id_ex_pc_plus4   (id_ex_pc_plus4),
      .id_ex_rs_val     (id_ex_rs_val),
      .id_ex_rt_val     (id_ex_rt_val),
      .id_ex_rs         (id_ex_rs),
      .id_ex_rt         (id_ex_rt),
      .id_ex_rd         (id_ex_rd),
      .id_ex_shamt      (id_ex_shamt),
      .id_ex_opcode     (id_ex_opcode),
      .id_ex_funct      (id_ex_funct),
      .id_ex_imm        (id_ex_imm)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just past it, away from the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic fl);
      if_id_valid    = valid;
      if_id_instr    = instr;
      if_id_pc_plus4 = pc4;
      flush          = fl;
   endtask

   task automatic setWriteback(input logic rw, input logic [4:0] wr,
                               input logic [31:0] wd, input logic jal,
                               input logic [31:0] link);
      wb_reg_write      = rw;
      wb_write_register = wr;
      wb_write_data     = wd;
      wb_jal_write      = jal;
      wb_pc_plus4       = link;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
         $error("[TB] %s differs", tag);
      end
   endtask

   initial begin
      reset      = 1'b1;
      rf_rs_data = 32'h11111111;
      rf_rt_data = 32'h22222222;
      setWriteback(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b1, ADD_3_5_6, 32'h00000100, 1'b0);

      tick();
      tick();
      checkOutput("reset_valid", {31'h0, id_ex_valid}, 32'h0);
      checkOutput("reset_rs_val", id_ex_rs_val, 32'h0);
      checkOutput("reset_stall", {31'h0, stall}, 32'h0);

      reset = 1'b0;
      tick();
      checkOutput("first_valid", {31'h0, id_ex_valid}, 32'h1);
      checkOutput("first_rs_val", id_ex_rs_val, 32'h11111111);
      checkOutput("first_rt_val", id_ex_rt_val, 32'h22222222);
      checkOutput("first_rs", {27'h0, id_ex_rs}, 32'd5);
      checkOutput("first_rt", {27'h0, id_ex_rt}, 32'd6);
      checkOutput("first_rd", {27'h0, id_ex_rd}, 32'd3);
      checkOutput("first_funct", {26'h0, id_ex_funct}, 32'h20);
      checkOutput("first_pc4", id_ex_pc_plus4, 32'h00000100);
      checkOutput("first_imm", id_ex_imm, 32'h00001820);
      checkOutput("first_mem_read", {31'h0, id_ex_mem_read}, 32'h0);

      #2 reset = 1'b1;
      #1;
      checkOutput("async_reset_valid", {31'h0, id_ex_valid}, 32'h0);
      checkOutput("async_reset_rd", {27'h0, id_ex_rd}, 32'h0);
      #1 reset = 1'b0;

      setWriteback(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0);
      tick();
      checkOutput("bypass_rs", id_ex_rs_val, 32'hDEADBEEF);
      checkOutput("bypass_rt_untouched", id_ex_rt_val, 32'h22222222);

      applyStimulus(1'b1, ADD_3_0_5, 32'h00000104, 1'b0);
      tick();
      checkOutput("bypass_rs_zero", id_ex_rs_val, 32'h0);
      checkOutput("bypass_rt", id_ex_rt_val, 32'hDEADBEEF);

      setWriteback(1'b0, 5'd0, 32'h0, 1'b1, 32'h00000044);
      applyStimulus(1'b1, JR_31, 32'h00000108, 1'b0);
      tick();
      checkOutput("jal_bypass", id_ex_rs_val, 32'h00000044);
      checkOutput("jal_rt_zero", id_ex_rt_val, 32'h0);

      setWriteback(1'b1, 5'd31, 32'h00000099, 1'b1, 32'h00000044);
      tick();
      checkOutput("wb_over_jal", id_ex_rs_val, 32'h00000099);

      setWriteback(1'b1, 5'd4, 32'h00000099, 1'b1, 32'h00000044);
      tick();
      checkOutput("jal_suppressed", id_ex_rs_val, 32'h11111111);

      setWriteback(1'b1, 5'd0, 32'h00000099, 1'b1, 32'h00000044);
      tick();
      checkOutput("jal_with_wb_r0", id_ex_rs_val, 32'h00000044);

      setWriteback(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b1, ORI_8000, 32'h0000010C, 1'b0);
      tick();
      checkOutput("ori_zero_ext", id_ex_imm, 32'h00008000);
      checkOutput("ori_opcode", {26'h0, id_ex_opcode}, 32'h0D);

      applyStimulus(1'b1, ADDI_8000, 32'h00000110, 1'b0);
      tick();
      checkOutput("addi_sign_ext", id_ex_imm, 32'hFFFF8000);

      // Load-use through rs
      applyStimulus(1'b1, LW_8_9, 32'h00000114, 1'b0);
      tick();
      checkOutput("lw_mem_read", {31'h0, id_ex_mem_read}, 32'h1);
      checkOutput("lw_rt", {27'h0, id_ex_rt}, 32'd8);
      applyStimulus(1'b1, ADD_10_8_11, 32'h00000118, 1'b0);
      #1;
      checkOutput("rs_use_stall", {31'h0, stall}, 32'h1);
      tick();
      checkOutput("bubble_valid", {31'h0, id_ex_valid}, 32'h0);
      checkOutput("bubble_mem_read", {31'h0, id_ex_mem_read}, 32'h0);
      checkOutput("bubble_rs_val", id_ex_rs_val, 32'h0);
      checkOutput("stall_one_cycle", {31'h0, stall}, 32'h0);
      tick();
      checkOutput("after_stall_valid", {31'h0, id_ex_valid}, 32'h1);
      checkOutput("after_stall_rd", {27'h0, id_ex_rd}, 32'd10);

      // Load-use through rt only
      applyStimulus(1'b1, LW_8_9, 32'h0000011C, 1'b0);
      tick();
      applyStimulus(1'b1, SW_8_2, 32'h00000120, 1'b0);
      #1;
      checkOutput("rt_use_stall", {31'h0, stall}, 32'h1);
      tick();
      checkOutput("sw_bubble", {31'h0, id_ex_valid}, 32'h0);

      // addi uses rt only as destination
      applyStimulus(1'b1, LW_8_9, 32'h00000124, 1'b0);
      tick();
      applyStimulus(1'b1, ADDI_8_9, 32'h00000128, 1'b0);
      #1;
      checkOutput("addi_rt_dest_no_stall", {31'h0, stall}, 32'h0);
      tick();
      checkOutput("addi_loaded", {31'h0, id_ex_valid}, 32'h1);

      applyStimulus(1'b1, LW_8_9, 32'h0000012C, 1'b0);
      tick();
      applyStimulus(1'b1, ADDI_8_8, 32'h00000130, 1'b0);
      #1;
      checkOutput("addi_rs_stall", {31'h0, stall}, 32'h1);
      applyStimulus(1'b0, ADDI_8_8, 32'h00000130, 1'b0);
      #1;
      checkOutput("invalid_id_no_stall", {31'h0, stall}, 32'h0);
      applyStimulus(1'b1, LW_10_8, 32'h00000130, 1'b0);
      #1;
      checkOutput("load_load_stall", {31'h0, stall}, 32'h1);
      tick();
      checkOutput("load_load_stall_clears", {31'h0, stall}, 32'h0);
      tick();
      checkOutput("load_load_proceeds", {31'h0, id_ex_mem_read}, 32'h1);
      checkOutput("load_load_rt", {27'h0, id_ex_rt}, 32'd10);

      // Flush wins over a simultaneous hazard
      applyStimulus(1'b1, LW_8_9, 32'h00000134, 1'b0);
      tick();
      applyStimulus(1'b1, ADD_10_8_11, 32'h00000138, 1'b1);
      #1;
      checkOutput("flush_hazard_stall", {31'h0, stall}, 32'h0);
      tick();
      checkOutput("flush_valid", {31'h0, id_ex_valid}, 32'h0);
      applyStimulus(1'b1, ORI_8000, 32'h0000013C, 1'b0);
      tick();
      checkOutput("post_flush_valid", {31'h0, id_ex_valid}, 32'h1);
      checkOutput("post_flush_opcode", {26'h0, id_ex_opcode}, 32'h0D);
      checkOutput("post_flush_pc4", id_ex_pc_plus4, 32'h0000013C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
